// File: rtl/and_vec_checker.sv
// and_vec_checker
//
// Sweeps every operand combination onto a combinational and_gate. Each
// combination is held for HOLD cycles. The gate's y is sampled on the last
// cycle of each hold and compared with the bitwise AND of the operands. The
// block reports the mismatch count and a pass/done status.
//
// Parameters
//   WIDTH  operand width, 1..4
//   HOLD   cycles each vector is held before y is sampled, >= 1
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      begins a sweep when sampled high in IDLE or DONE
//   a_o, b_o   operands to the gate; the upper and lower halves of vec_idx
//   y_i        gate result, combinational from a_o/b_o
//   busy       high while sweeping
//   done       high after a completed sweep, until restart or reset
//   pass       done with zero mismatches
//   err_count  mismatching vectors in the current or last sweep
//   vec_idx    index of the vector currently driven ({a_o,b_o})
//   fail_vec   index of the first mismatching vector (optional)
//   fail_y     y_i captured at the first mismatch (optional)
//
// Optional feature: define AND_VEC_CHK_FAILCAP_EN to add fail_vec/fail_y and
// their capture registers. Without it those ports and registers do not exist.
module and_vec_checker #(
  parameter int WIDTH = 1,
  parameter int HOLD  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   a_o,
  output logic [WIDTH-1:0]   b_o,
  input  logic [WIDTH-1:0]   y_i,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic [2*WIDTH-1:0] vec_idx
`ifdef AND_VEC_CHK_FAILCAP_EN
  ,
  output logic [2*WIDTH-1:0] fail_vec,
  output logic [WIDTH-1:0]   fail_y
`endif
);

  localparam int NVEC = 2**(2*WIDTH);
  localparam int IW   = 2*WIDTH;
  localparam int EW   = 2*WIDTH+1;
  localparam int HW   = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [HW-1:0] LAST_CNT = HW'(HOLD-1);
  localparam logic [IW-1:0] LAST_VEC = IW'(NVEC-1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [HW-1:0] hold_cnt;
  logic          sample_edge;
  logic          last_vec;
  logic          mismatch;
  logic          sweep_start;

  // Whole-vector compare: any number of differing bits is one error.
  function automatic logic vec_mismatch(input logic [WIDTH-1:0] y,
                                        input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b);
    return (y != (a & b));
  endfunction

  // The operands are slices of the registered index, so they are glitch-free
  // register outputs and always equal vec_idx.
  assign a_o = vec_idx[IW-1:WIDTH];
  assign b_o = vec_idx[WIDTH-1:0];

  assign sample_edge = (state == S_DRIVE) && (hold_cnt == LAST_CNT);
  assign last_vec    = (vec_idx == LAST_VEC);
  assign mismatch    = vec_mismatch(y_i, a_o, b_o);
  // A start while sweeping is ignored; a start in DONE fully re-clears.
  assign sweep_start = start && ((state == S_IDLE) || (state == S_DONE));

  assign busy = (state == S_DRIVE);
  assign done = (state == S_DONE);
  assign pass = done && (err_count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_DRIVE;
      S_DRIVE: if (sample_edge && last_vec) state_nxt = S_DONE;
      S_DONE:  if (start) state_nxt = S_DRIVE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || sweep_start || (state == S_IDLE)) begin
      vec_idx   <= '0;
      hold_cnt  <= '0;
      err_count <= '0;
    end else if (state == S_DRIVE) begin
      if (sample_edge) begin
        if (mismatch) begin
          err_count <= err_count + EW'(1);
        end
        // On the final vector the index stays put so DONE shows the last vector.
        if (!last_vec) begin
          vec_idx  <= vec_idx + IW'(1);
          hold_cnt <= '0;
        end
      end else begin
        hold_cnt <= hold_cnt + HW'(1);
      end
    end
  end

`ifdef AND_VEC_CHK_FAILCAP_EN
  // err_count still at zero on a mismatching sample marks the first failure.
  always_ff @(posedge clk) begin
    if (rst || sweep_start) begin
      fail_vec <= '0;
      fail_y   <= '0;
    end else if (sample_edge && mismatch && (err_count == '0)) begin
      fail_vec <= vec_idx;
      fail_y   <= y_i;
    end
  end
`endif

endmodule

// File: tb/tb_and_vec_checker.sv
module tb_and_vec_checker;

  logic       clk;
  logic       rst;
  int         n_cmp;
  int         n_bad;

  // Instance 1: WIDTH=1, HOLD=10, gate model selectable
  logic       start1;
  logic [1:0] mode;      // 0 correct AND, 1 stuck-at-0, 2 stuck-at-1
  logic [0:0] a1, b1, y1;
  logic       busy1, done1, pass1;
  logic [2:0] err1;
  logic [1:0] vec1;

  // Instance 2: WIDTH=2, HOLD=1, correct gate
  logic       start2;
  logic [1:0] a2, b2, y2;
  logic       busy2, done2, pass2;
  logic [4:0] err2;
  logic [3:0] vec2;

`ifdef AND_VEC_CHK_FAILCAP_EN
  logic [1:0] fv1;
  logic [0:0] fy1;
  logic [3:0] fv2;
  logic [1:0] fy2;
`endif

  always_comb begin
    y1 = a1 & b1;
    case (mode)
      2'd1:    y1 = 1'b0;
      2'd2:    y1 = 1'b1;
      default: y1 = a1 & b1;
    endcase
  end

  assign y2 = a2 & b2;

  and_vec_checker #(.WIDTH(1), .HOLD(10)) u1 (
    .clk(clk), .rst(rst), .start(start1),
    .a_o(a1), .b_o(b1), .y_i(y1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .vec_idx(vec1)
`ifdef AND_VEC_CHK_FAILCAP_EN
    , .fail_vec(fv1), .fail_y(fy1)
`endif
  );

  and_vec_checker #(.WIDTH(2), .HOLD(1)) u2 (
    .clk(clk), .rst(rst), .start(start2),
    .a_o(a2), .b_o(b2), .y_i(y2),
    .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .vec_idx(vec2)
`ifdef AND_VEC_CHK_FAILCAP_EN
    , .fail_vec(fv2), .fail_y(fy2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; start1 = 1'b1; start2 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({busy1, done1, pass1, err1, vec1, a1, b1} !== 10'b0) begin
      n_bad++;
      $display("FAIL reset_u1: got busy=%b done=%b pass=%b err=%0d vec=%0d a=%b b=%b want all 0",
               busy1, done1, pass1, err1, vec1, a1, b1);
    end
    n_cmp++;
    if ({busy2, done2, pass2, err2, vec2, a2, b2} !== 16'b0) begin
      n_bad++;
      $display("FAIL reset_u2: got busy=%b done=%b pass=%b err=%0d vec=%0d want all 0",
               busy2, done2, pass2, err2, vec2);
    end
`ifdef AND_VEC_CHK_FAILCAP_EN
    n_cmp++;
    if ({fv1, fy1, fv2, fy2} !== 9'b0) begin
      n_bad++;
      $display("FAIL reset_failcap: got fv1=%0d fy1=%0d fv2=%0d fy2=%0d want 0", fv1, fy1, fv2, fy2);
    end
`endif
    rst = 1'b0; start1 = 1'b0; start2 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy1, done1, busy2, done2} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_idle: got busy1=%b done1=%b busy2=%b done2=%b want 0", busy1, done1, busy2, done2);
    end
  endtask

  // Full WIDTH=1 sweep on u1 with the current gate mode.
  task automatic sweep1(input string name, input int exp_err, input int exp_fv, input int exp_fy);
    logic [1:0] ev;
    $display("sweep %s: expecting err=%0d fail_vec=%0d fail_y=%0d", name, exp_err, exp_fv, exp_fy);
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int n = 0; n < 40; n++) begin
      ev = 2'(n / 10);
      n_cmp++;
      if ({busy1, done1, vec1, a1, b1} !== {1'b1, 1'b0, ev, ev[1], ev[0]}) begin
        n_bad++;
        $display("FAIL %s_step%0d: got busy=%b done=%b vec=%0d ab=%b%b want busy=1 done=0 vec=%0d",
                 name, n, busy1, done1, vec1, a1, b1, ev);
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({busy1, done1, vec1, a1, b1} !== 6'b01_11_11) begin
      n_bad++;
      $display("FAIL %s_done: got busy=%b done=%b vec=%0d ab=%b%b want busy=0 done=1 vec=3 ab=11",
               name, busy1, done1, vec1, a1, b1);
    end
    n_cmp++;
    if (err1 !== 3'(exp_err) || pass1 !== (exp_err == 0)) begin
      n_bad++;
      $display("FAIL %s_result: got err=%0d pass=%b want err=%0d pass=%b",
               name, err1, pass1, exp_err, (exp_err == 0));
    end
`ifdef AND_VEC_CHK_FAILCAP_EN
    n_cmp++;
    if (fv1 !== 2'(exp_fv) || fy1 !== 1'(exp_fy)) begin
      n_bad++;
      $display("FAIL %s_failcap: got fail_vec=%0d fail_y=%0d want %0d %0d", name, fv1, fy1, exp_fv, exp_fy);
    end
`endif
  endtask

  task automatic test_golden();
    mode = 2'd0;
    sweep1("golden", 0, 0, 0);
  endtask

  task automatic test_stuck0();
    mode = 2'd1;
    sweep1("stuck0", 1, 3, 0);
  endtask

  task automatic test_stuck1();
    mode = 2'd2;
    sweep1("stuck1", 3, 0, 1);
  endtask

  task automatic test_reset_mid();
    logic seen_done;
    mode = 2'd2;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (vec1 !== 2'd2 || err1 !== 3'd2) begin
      n_bad++;
      $display("FAIL rstmid_pre: got vec=%0d err=%0d want vec=2 err=2", vec1, err1);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({busy1, done1, pass1, err1, vec1, a1, b1} !== 10'b0) begin
      n_bad++;
      $display("FAIL rstmid_clear: got busy=%b done=%b pass=%b err=%0d vec=%0d want all 0",
               busy1, done1, pass1, err1, vec1);
    end
`ifdef AND_VEC_CHK_FAILCAP_EN
    n_cmp++;
    if (fv1 !== 2'd0 || fy1 !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_failcap: got fail_vec=%0d fail_y=%0d want 0 0", fv1, fy1);
    end
`endif
    seen_done = 1'b0;
    for (int n = 0; n < 25; n++) begin
      if (done1 === 1'b1 || busy1 === 1'b1) seen_done = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (seen_done !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_nodone: got done/busy seen=%b want 0", seen_done);
    end
    mode = 2'd0;
    sweep1("rstmid_resweep", 0, 0, 0);
  endtask

  task automatic test_start_busy();
    logic got_done;
    mode = 2'd2;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 40; n++) begin
      if (n % 10 == 5) begin
        n_cmp++;
        if (vec1 !== 2'(n / 10) || busy1 !== 1'b1) begin
          n_bad++;
          $display("FAIL startbusy_step%0d: got vec=%0d busy=%b want vec=%0d busy=1", n, vec1, busy1, n / 10);
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (done1 !== 1'b1 || err1 !== 3'd3) begin
      n_bad++;
      $display("FAIL startbusy_done: got done=%b err=%0d want done=1 err=3", done1, err1);
    end
    mode = 2'd0;
    @(negedge clk);
    n_cmp++;
    if ({busy1, done1, vec1, err1} !== 7'b10_00_000) begin
      n_bad++;
      $display("FAIL startbusy_restart: got busy=%b done=%b vec=%0d err=%0d want busy=1 done=0 vec=0 err=0",
               busy1, done1, vec1, err1);
    end
`ifdef AND_VEC_CHK_FAILCAP_EN
    n_cmp++;
    if (fv1 !== 2'd0 || fy1 !== 1'b0) begin
      n_bad++;
      $display("FAIL startbusy_failcap: got fail_vec=%0d fail_y=%0d want 0 0", fv1, fy1);
    end
`endif
    start1 = 1'b0;
    got_done = 1'b0;
    for (int n = 0; n < 60 && !got_done; n++) begin
      @(negedge clk);
      if (done1 === 1'b1) got_done = 1'b1;
    end
    n_cmp++;
    if (got_done !== 1'b1 || err1 !== 3'd0 || pass1 !== 1'b1) begin
      n_bad++;
      $display("FAIL startbusy_final: got done=%b err=%0d pass=%b want 1 0 1", got_done, err1, pass1);
    end
  endtask

  task automatic test_w2h1();
    logic [3:0] nv;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int n = 0; n < 16; n++) begin
      nv = 4'(n);
      n_cmp++;
      if ({busy2, done2, vec2, a2, b2} !== {1'b1, 1'b0, nv, nv}) begin
        n_bad++;
        $display("FAIL w2h1_step%0d: got busy=%b done=%b vec=%0d a=%0d b=%0d want vec=%0d",
                 n, busy2, done2, vec2, a2, b2, nv);
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({busy2, done2, pass2, err2, vec2} !== {1'b0, 1'b1, 1'b1, 5'd0, 4'hF}) begin
      n_bad++;
      $display("FAIL w2h1_done: got busy=%b done=%b pass=%b err=%0d vec=%0d want 0 1 1 0 15",
               busy2, done2, pass2, err2, vec2);
    end
`ifdef AND_VEC_CHK_FAILCAP_EN
    n_cmp++;
    if (fv2 !== 4'd0 || fy2 !== 2'd0) begin
      n_bad++;
      $display("FAIL w2h1_failcap: got fail_vec=%0d fail_y=%0d want 0 0", fv2, fy2);
    end
`endif
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    mode = 2'd0;
    test_reset();
    test_golden();
    test_stuck0();
    test_stuck1();
    test_reset_mid();
    test_start_busy();
    test_w2h1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
